pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Parametrised elastic pipeline register for inter-stage boundaries (ID/EX, EX/MEM, MEM/WB).
//  Carries a control bundle, PC and NUM_OPS operand lanes under a valid/ready handshake.
//  A 2-entry skid buffer keeps in_ready registered, so upstream sees no combinational path
//  from out_ready. Adds back-pressure stall and squash-on-flush, which the fixed-width stage regs lack.
// PARAMETERS
//  CTRL_W      8   control bundle width (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD)
//  PC_W        32  program-counter width
//  DATA_W      32  width of one operand lane
//  NUM_OPS     2   operand lanes (Val_Rn, Val_Rm, ...); >=1
//  CLEAR_DATA  1   1: PC/data regs zeroed on reset and flush; 0: only ctrl/state cleared
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous reset, active-low
//  flush      in   1                  synchronous squash of all held entries
//  in_valid   in   1                  upstream entry present
//  in_ready   out  1                  stage can accept (registered)
//  in_ctrl    in   CTRL_W             upstream control bundle
//  in_pc      in   PC_W               upstream PC
//  in_data    in   NUM_OPS*DATA_W     operand lanes, lane k at [k*DATA_W +: DATA_W]
//  out_valid  out  1                  downstream entry present
//  out_ready  in   1                  downstream accepts
//  out_ctrl   out  CTRL_W             held control bundle
//  out_pc     out  PC_W               held PC
//  out_data   out  NUM_OPS*DATA_W     held operand lanes
//  occupancy  out  2                  entries held: 0,1,2
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Storage: MAIN slot (drives outputs) and SKID slot. State EMPTY/ONE/FULL = occupancy 0/1/2.
//  - out_valid = (state != EMPTY); in_ready_q <= (next_state != FULL) registered.
//  - EMPTY: in_fire -> ONE, MAIN<=in. out_fire impossible.
//  - ONE: in_fire&out_fire -> ONE, MAIN<=in; in_fire only -> FULL, SKID<=in;
//         out_fire only -> EMPTY; neither -> hold.
//  - FULL: in_ready=0; out_fire -> ONE, MAIN<=SKID; else hold.
//  - Order preserved; no entry duplicated or lost except by flush. Latency 1 cycle when empty.
//  - Outputs stable while out_valid & !out_ready (no change until out_fire).
//  - flush (rst high): next state EMPTY; MAIN/SKID ctrl <= 0; PC/data <= 0 iff CLEAR_DATA.
//    Same-cycle in_fire is discarded; same-cycle out_fire completes downstream as normal.
//    in_ready = 1 the cycle after flush.
//  - rst low (priority over flush): state EMPTY, out_valid=0, out_ctrl=0, occupancy=0,
//    in_ready=0 during reset, 1 the first cycle after release; PC/data 0 iff CLEAR_DATA.
//  - Reset mid-transfer: all held entries lost, no partial output.
//  - out_ctrl=0 whenever out_valid=0, so downstream enables never fire on a bubble.
//  - No arithmetic; widths pass through unchanged; occupancy never exceeds 2.
// STRUCTURE
//  - Shared package pipe_pkg: ctrl bit positions (CTRL_WB_EN=0, CTRL_MEM_R=1, CTRL_MEM_W=2,
//    CTRL_B=3, CTRL_S=4, CTRL_CMD=7:5... sized by CTRL_W), state encodings ST_EMPTY/ONE/FULL.
//  - One sub-module: pipe_slot (CTRL_W+PC_W+NUM_OPS*DATA_W register with load, clear, CLEAR_DATA),
//    instantiated twice (MAIN, SKID). Top holds FSM, in_ready_q, output muxing.
// TESTING
//  1 Pass-through: out_ready=1, stream pc 0x0,0x4,0x8 one per cycle -> out_pc same order,
//    1-cycle latency, in_ready stays 1, occupancy 1.
//  2 Back-pressure: out_ready=0, send 3 entries -> occupancy 2, in_ready=0 after 2nd;
//    3rd held upstream; release -> outputs in order 0x0,0x4,0x8, none lost.
//  3 Flush when FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy 0,
//    in_ready=1; flushed-cycle input never appears at output.
//  4 Reset: rst=0 mid-stream with occupancy 2 -> out_valid=0, in_ready=0 during reset,
//    in_ready=1 first cycle after release; CLEAR_DATA=1 gives out_pc=0, out_data=0.
//  5 Random valid/ready (10k cycles, NUM_OPS=3, DATA_W=16) vs scoreboard FIFO ->
//    exact order match, outputs stable while stalled, out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// control-bundle bit positions and the occupancy state encoding.
package pipe_pkg;

    localparam int CTRL_WB_EN   = 0;
    localparam int CTRL_MEM_R   = 1;
    localparam int CTRL_MEM_W   = 2;
    localparam int CTRL_B       = 3;
    localparam int CTRL_S       = 4;
    localparam int CTRL_CMD_LSB = 5;
    localparam int CTRL_CMD_MSB = 7;

    // Encoding equals the number of held entries, so it doubles as occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the skid register: control bundle, PC and operand lanes.
// Clear beats load; PC/data clearing is optional via CLEAR_DATA.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_OPS    = 2,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                      clk,
    input  logic                      i_clr,
    input  logic                      i_load,
    input  logic [CTRL_W-1:0]         i_ctrl,
    input  logic [PC_W-1:0]           i_pc,
    input  logic [NUM_OPS*DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0]         o_ctrl,
    output logic [PC_W-1:0]           o_pc,
    output logic [NUM_OPS*DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0]         r_ctrl;
    logic [PC_W-1:0]           r_pc;
    logic [NUM_OPS*DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_ctrl <= '0;
        end else if (i_load) begin
            r_ctrl <= i_ctrl;
        end
    end

    generate
        if (CLEAR_DATA) begin : g_clr_data
            always_ff @(posedge clk) begin
                if (i_clr) begin
                    r_pc   <= '0;
                    r_data <= '0;
                end else if (i_load) begin
                    r_pc   <= i_pc;
                    r_data <= i_data;
                end
            end
        end else begin : g_keep_data
            // Payload is only meaningful under valid, so it needs no clear.
            always_ff @(posedge clk) begin
                if (i_load) begin
                    r_pc   <= i_pc;
                    r_data <= i_data;
                end
            end
        end
    endgenerate

    assign o_ctrl = r_ctrl;
    assign o_pc   = r_pc;
    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline register with a 2-entry skid buffer: registered in_ready,
// back-pressure stall and squash-on-flush for inter-stage boundaries.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_OPS    = 2,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [NUM_OPS*DATA_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [PC_W-1:0]           out_pc,
    output logic [NUM_OPS*DATA_W-1:0] out_data,
    output logic [1:0]                occupancy
);

    localparam int DW = NUM_OPS * DATA_W;

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_clr;
    logic              w_main_load;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [PC_W-1:0]   w_main_pc_in;
    logic [DW-1:0]     w_main_data_in;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [PC_W-1:0]   w_skid_pc;
    logic [DW-1:0]     w_skid_data;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_clr      = ~rst | flush;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_skid_load = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = ST_ONE;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // A flushed cycle drops any incoming entry; an outgoing one already left.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_pc_in   = w_main_from_skid ? w_skid_pc   : in_pc;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(
        .CTRL_W     (CTRL_W),
        .PC_W       (PC_W),
        .DATA_W     (DATA_W),
        .NUM_OPS    (NUM_OPS),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk    (clk),
        .i_clr  (w_clr),
        .i_load (w_main_load),
        .i_ctrl (w_main_ctrl_in),
        .i_pc   (w_main_pc_in),
        .i_data (w_main_data_in),
        .o_ctrl (w_main_ctrl),
        .o_pc   (out_pc),
        .o_data (out_data)
    );

    pipe_slot #(
        .CTRL_W     (CTRL_W),
        .PC_W       (PC_W),
        .DATA_W     (DATA_W),
        .NUM_OPS    (NUM_OPS),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk    (clk),
        .i_clr  (w_clr),
        .i_load (w_skid_load),
        .i_ctrl (in_ctrl),
        .i_pc   (in_pc),
        .i_data (in_data),
        .o_ctrl (w_skid_ctrl),
        .o_pc   (w_skid_pc),
        .o_data (w_skid_data)
    );

    // Bubbles must never carry live enables downstream.
    assign out_valid = (r_state != ST_EMPTY);
    assign out_ctrl  = out_valid ? w_main_ctrl : '0;
    assign in_ready  = r_in_ready;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed and randomised checks of pipe_stage_skid_reg against hand-computed values
// and a scoreboard FIFO.
module tb_pipe_stage_skid_reg;

    localparam int CTRL_W  = 8;
    localparam int PC_W    = 32;
    localparam int DATA_W  = 16;
    localparam int NUM_OPS = 3;
    localparam int DW      = NUM_OPS * DATA_W;
    localparam int PW      = CTRL_W + PC_W + DW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic [DW-1:0]     in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [PC_W-1:0]   out_pc;
    logic [DW-1:0]     out_data;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_errors = 0;

    logic [PW-1:0] sb[$];
    logic [PW-1:0] prev_out;
    logic          prev_stall;
    logic          will_in;
    logic          will_out;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .CTRL_W     (CTRL_W),
        .PC_W       (PC_W),
        .DATA_W     (DATA_W),
        .NUM_OPS    (NUM_OPS),
        .CLEAR_DATA (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_pc    = pc;
        in_ctrl  = c;
        in_data  = {pc[15:0] ^ 16'h00aa, pc[15:0], ~pc[15:0]};
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ctrl", out_ctrl, 0);
        rst = 1'b1;
        step();
        chk("rel_ready", in_ready, 1);

        // Pass-through, 1-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(4 * i), 8'(8'h11 + i));
            step();
            chk("pt_valid", out_valid, 1);
            chk("pt_pc", out_pc, 4 * i);
            chk("pt_ctrl", out_ctrl, 8'h11 + i);
            chk("pt_ready", in_ready, 1);
            chk("pt_occ", occupancy, 1);
        end
        drive(1'b0, 32'h0, 8'h0);
        step();
        chk("pt_drain_valid", out_valid, 0);
        chk("pt_drain_ctrl", out_ctrl, 0);
        chk("pt_drain_occ", occupancy, 0);

        // Back-pressure
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 8'h21);
        step();
        chk("bp_occ1", occupancy, 1);
        chk("bp_ready1", in_ready, 1);
        drive(1'b1, 32'h4, 8'h22);
        step();
        chk("bp_occ2", occupancy, 2);
        chk("bp_ready2", in_ready, 0);
        drive(1'b1, 32'h8, 8'h23);
        step();
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_hold_pc", out_pc, 32'h0);
        chk("bp_hold_ctrl", out_ctrl, 8'h21);
        chk("bp_hold_data", out_data, {16'h00aa, 16'h0000, 16'hffff});
        out_ready = 1'b1;
        step();
        chk("bp_rel_pc1", out_pc, 32'h4);
        chk("bp_rel_ctrl1", out_ctrl, 8'h22);
        chk("bp_rel_ready", in_ready, 1);
        step();
        chk("bp_rel_pc2", out_pc, 32'h8);
        chk("bp_rel_ctrl2", out_ctrl, 8'h23);
        drive(1'b0, 32'h0, 8'h0);
        step();
        chk("bp_empty", occupancy, 0);

        // Flush when full, with input offered
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 8'h31);
        step();
        drive(1'b1, 32'h104, 8'h32);
        step();
        chk("fl_full", occupancy, 2);
        drive(1'b1, 32'h108, 8'h33);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0);
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_pc", out_pc, 0);
        // Flush while an input actually fires: it must be dropped
        drive(1'b1, 32'h10c, 8'h34);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0);
        chk("fl_drop_occ", occupancy, 0);
        step();
        chk("fl_drop_valid", out_valid, 0);

        // Reset mid-stream with two entries held
        drive(1'b1, 32'h200, 8'h41);
        step();
        drive(1'b1, 32'h204, 8'h42);
        step();
        chk("mr_full", occupancy, 2);
        rst = 1'b0;
        step();
        chk("mr_valid", out_valid, 0);
        chk("mr_ready", in_ready, 0);
        chk("mr_occ", occupancy, 0);
        chk("mr_pc", out_pc, 0);
        chk("mr_data", out_data, 0);
        step();
        chk("mr_ready2", in_ready, 0);
        drive(1'b0, 32'h0, 8'h0);
        rst = 1'b1;
        step();
        chk("mr_rel_ready", in_ready, 1);
        chk("mr_rel_valid", out_valid, 0);

        // Random valid/ready against a scoreboard FIFO
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_ctrl   = 8'($urandom);
            in_pc     = $urandom;
            in_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
            will_in   = in_valid && in_ready;
            will_out  = out_valid && out_ready;
            if (will_out) begin
                if (sb.size() == 0) begin
                    chk("rnd_underflow", 1, 0);
                end else begin
                    chk("rnd_order", {out_ctrl, out_pc, out_data}, sb[0]);
                    void'(sb.pop_front());
                end
            end
            if (will_in) begin
                sb.push_back({in_ctrl, in_pc, in_data});
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_ctrl, out_pc, out_data};
            step();
            chk("rnd_occ", occupancy, sb.size());
            if (!out_valid) begin
                chk("rnd_bubble_ctrl", out_ctrl, 0);
            end
            if (prev_stall) begin
                chk("rnd_stable", {out_ctrl, out_pc, out_data}, prev_out);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (out_valid) begin
                chk("drain_order", {out_ctrl, out_pc, out_data}, sb[0]);
                void'(sb.pop_front());
            end
            step();
        end
        chk("drain_empty", occupancy, 0);
        chk("drain_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
